// File: rtl/seg7_monitor_if.sv
// Seven-segment display bus as seen by the receive-side monitor.
// The driver (master) owns seg and observes the checker results.
// The monitor (slave) samples seg and produces the decoded status.
interface seg7_monitor_if;
  logic [7:0] seg;
  logic [3:0] digit;
  logic       valid;
  logic       dp;
  logic       step;
  logic       seq_err;
  logic       bad_pat;
  logic       stall;
  logic [7:0] err_cnt;

  modport master (
    output seg,
    input  digit, valid, dp, step, seq_err, bad_pat, stall, err_cnt
  );

  modport slave (
    input  seg,
    output digit, valid, dp, step, seq_err, bad_pat, stall, err_cnt
  );
endinterface

// File: rtl/seg7_monitor.sv
// Receive-side checker for a 7-segment counter display.
// The block debounces the segment bus, decodes accepted patterns back to BCD,
// and checks that the digits follow 0..9 with wrap. Sequence breaks, illegal
// patterns and stalls raise one-cycle pulses and feed a saturating error count.
module seg7_monitor #(
  parameter int STABLE_CYC = 2,
  parameter int TIMEOUT    = 16,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic           clk,
  input  logic           rst,
  seg7_monitor_if.slave  bus
);

  typedef enum logic {SYNC, TRACK} state_t;

  localparam logic [3:0] STABLE    = 4'(STABLE_CYC);
  localparam logic [7:0] TIMER_MAX = 8'(TIMEOUT - 1);

  // Map a 7-bit segment pattern to {legal, bcd}.
  function automatic logic [4:0] decode(input logic [6:0] pat);
    case (pat)
      7'h3F:   decode = {1'b1, 4'd0};
      7'h06:   decode = {1'b1, 4'd1};
      7'h5B:   decode = {1'b1, 4'd2};
      7'h4F:   decode = {1'b1, 4'd3};
      7'h66:   decode = {1'b1, 4'd4};
      7'h6D:   decode = {1'b1, 4'd5};
      7'h7D:   decode = {1'b1, 4'd6};
      7'h07:   decode = {1'b1, 4'd7};
      7'h7F:   decode = {1'b1, 4'd8};
      7'h6F:   decode = {1'b1, 4'd9};
      default: decode = 5'b0;
    endcase
  endfunction

  // Polarity is normalised once so every later stage sees active-high segments.
  logic [7:0] seg_in;
  assign seg_in = ACTIVE_LOW ? ~bus.seg : bus.seg;

  // Glitch filter state.
  logic [7:0] samp;
  logic [7:0] acc;
  logic [3:0] run;
  logic [3:0] run_next;
  logic       match;
  logic       accept;

  // Checker state and registered outputs.
  state_t     state;
  logic [7:0] timer;
  logic [3:0] digit;
  logic       valid;
  logic       dp;
  logic       step;
  logic       seq_err;
  logic       bad_pat;
  logic       stall;
  logic [7:0] err_cnt;

  // Decode and next-event terms.
  logic [4:0] dec;
  logic       legal;
  logic       blank;
  logic [3:0] val;
  logic [3:0] succ;
  logic       do_step;
  logic       do_seq;
  logic       do_bad;
  logic       do_stall;

  // Run-length bookkeeping and the single acceptance strobe.
  // NOTE: every always_comb output gets a default first so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    match    = (seg_in == samp);
    run_next = 4'd1;
    if (match) begin
      run_next = (run == STABLE) ? run : run + 4'd1;
    end
    // The run must just now reach STABLE; a pattern already saturated there is
    // not accepted again, and a repeat of the last accepted pattern is ignored.
    accept = (run_next == STABLE) && (!match || (run != STABLE)) && (seg_in != acc);
  end

  // Classify the candidate pattern against the current digit and state.
  always_comb begin
    dec      = decode(seg_in[6:0]);
    legal    = dec[4];
    val      = dec[3:0];
    blank    = (seg_in[6:0] == 7'h00);
    succ     = (digit == 4'd9) ? 4'd0 : digit + 4'd1;
    do_step  = accept && legal && (state == TRACK) && (val == succ);
    do_seq   = accept && legal && (state == TRACK) && (val != succ) && (val != digit);
    do_bad   = accept && !legal && !blank;
    // An acceptance on the expiry edge takes priority over the stall.
    do_stall = !accept && (state == TRACK) && (timer == TIMER_MAX);
  end

  // Glitch filter: track the current run and remember the last accepted pattern.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp <= 8'h00;
      run  <= 4'd0;
      acc  <= 8'h00;
    end else begin
      samp <= seg_in;
      run  <= run_next;
      if (accept) begin
        acc <= seg_in;
      end
    end
  end

  // SYNC/TRACK checker with registered digit, flags, pulses and error count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= SYNC;
      timer   <= 8'd0;
      digit   <= 4'd0;
      valid   <= 1'b0;
      dp      <= 1'b0;
      step    <= 1'b0;
      seq_err <= 1'b0;
      bad_pat <= 1'b0;
      stall   <= 1'b0;
      err_cnt <= 8'd0;
    end else begin
      step    <= do_step;
      seq_err <= do_seq;
      bad_pat <= do_bad;
      stall   <= do_stall;
      if ((do_seq || do_bad || do_stall) && (err_cnt != 8'hFF)) begin
        err_cnt <= err_cnt + 8'd1;
      end

      if (accept) begin
        dp    <= seg_in[7];
        timer <= 8'd0;
        if (legal) begin
          // Same digit in TRACK means only dp moved; everything else reloads.
          if ((state == SYNC) || (val != digit)) begin
            digit <= val;
          end
          valid <= 1'b1;
          state <= TRACK;
        end else begin
          // Blank and illegal both drop back to SYNC; digit keeps its old value.
          valid <= 1'b0;
          state <= SYNC;
        end
      end else if (state == TRACK) begin
        if (timer == TIMER_MAX) begin
          valid <= 1'b0;
          state <= SYNC;
          timer <= 8'd0;
        end else begin
          timer <= timer + 8'd1;
        end
      end
    end
  end

  assign bus.digit   = digit;
  assign bus.valid   = valid;
  assign bus.dp      = dp;
  assign bus.step    = step;
  assign bus.seq_err = seq_err;
  assign bus.bad_pat = bad_pat;
  assign bus.stall   = stall;
  assign bus.err_cnt = err_cnt;

endmodule

// File: tb/tb_seg7_monitor.sv
// Self-checking bench for seg7_monitor. Two instances run side by side:
// u0 is active-high with STABLE_CYC=2/TIMEOUT=16, u1 is active-low with
// STABLE_CYC=1/TIMEOUT=5 and is fed the inverted pattern. A behavioural model
// works from the sample history and the digit table to predict both.
module tb_seg7_monitor;

  localparam int S0 = 2;
  localparam int T0 = 16;
  localparam int S1 = 1;
  localparam int T1 = 5;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg7_monitor_if bus0 ();
  seg7_monitor_if bus1 ();

  seg7_monitor #(.STABLE_CYC(S0), .TIMEOUT(T0), .ACTIVE_LOW(1'b0)) u0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  seg7_monitor #(.STABLE_CYC(S1), .TIMEOUT(T1), .ACTIVE_LOW(1'b1)) u1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] pats [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                            7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  logic [7:0] hist [2][16];
  int         hcnt    [2];
  logic [7:0] m_acc   [2];
  int         m_digit [2];
  bit         m_valid [2];
  bit         m_dp    [2];
  bit         m_trk   [2];
  int         m_idle  [2];
  bit         m_step  [2];
  bit         m_seq   [2];
  bit         m_bad   [2];
  bit         m_stall [2];
  int         m_err   [2];

  // 0..9 for a digit, -1 for blank, -2 for anything else.
  function automatic int digit_of(input logic [6:0] p);
    int r;
    r = (p == 7'h00) ? -1 : -2;
    for (int k = 0; k < 10; k++) begin
      if (pats[k] == p) r = k;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      hcnt[i] = 0;    m_acc[i] = 8'h00; m_digit[i] = 0; m_valid[i] = 0;
      m_dp[i] = 0;    m_trk[i] = 0;     m_idle[i] = 0;  m_err[i] = 0;
      m_step[i] = 0;  m_seq[i] = 0;     m_bad[i] = 0;   m_stall[i] = 0;
    end
  endtask

  task automatic model_step(input int i, input logic [7:0] pat);
    int  s, t, len, d;
    bit  same, acc_now;
    s = (i == 0) ? S0 : S1;
    t = (i == 0) ? T0 : T1;
    m_step[i] = 0; m_seq[i] = 0; m_bad[i] = 0; m_stall[i] = 0;
    for (int k = 15; k > 0; k--) hist[i][k] = hist[i][k-1];
    hist[i][0] = pat;
    if (hcnt[i] < 16) hcnt[i]++;
    // Length of the run of identical samples ending at this edge.
    len  = 0;
    same = 1;
    for (int k = 0; k < hcnt[i]; k++) begin
      if (same && hist[i][k] == pat) len++;
      else same = 0;
    end
    acc_now = (len == s) && (pat != m_acc[i]);
    if (acc_now) begin
      m_acc[i]  = pat;
      m_dp[i]   = pat[7];
      m_idle[i] = 0;
      d = digit_of(pat[6:0]);
      if (d == -1) begin
        m_valid[i] = 0; m_trk[i] = 0;
      end else if (d == -2) begin
        m_bad[i] = 1; m_valid[i] = 0; m_trk[i] = 0;
      end else if (!m_trk[i]) begin
        m_digit[i] = d; m_valid[i] = 1; m_trk[i] = 1;
      end else if (d == (m_digit[i] + 1) % 10) begin
        m_step[i] = 1; m_digit[i] = d;
      end else if (d != m_digit[i]) begin
        m_seq[i] = 1; m_digit[i] = d;
      end
    end else if (m_trk[i]) begin
      m_idle[i]++;
      if (m_idle[i] == t) begin
        m_stall[i] = 1; m_valid[i] = 0; m_trk[i] = 0; m_idle[i] = 0;
      end
    end
    if (m_seq[i] || m_bad[i] || m_stall[i]) begin
      if (m_err[i] < 255) m_err[i]++;
    end
  endtask

  // ---------------- comparison ----------------
  int cnt_step0  = 0;
  int cnt_seq0   = 0;
  int cnt_bad0   = 0;
  int cnt_stall0 = 0;

  task automatic compare_all();
    check("u0_digit",   32'(bus0.digit),   32'(m_digit[0]));
    check("u0_valid",   32'(bus0.valid),   32'(m_valid[0]));
    check("u0_dp",      32'(bus0.dp),      32'(m_dp[0]));
    check("u0_step",    32'(bus0.step),    32'(m_step[0]));
    check("u0_seq_err", 32'(bus0.seq_err), 32'(m_seq[0]));
    check("u0_bad_pat", 32'(bus0.bad_pat), 32'(m_bad[0]));
    check("u0_stall",   32'(bus0.stall),   32'(m_stall[0]));
    check("u0_err_cnt", 32'(bus0.err_cnt), 32'(m_err[0]));
    check("u1_digit",   32'(bus1.digit),   32'(m_digit[1]));
    check("u1_valid",   32'(bus1.valid),   32'(m_valid[1]));
    check("u1_dp",      32'(bus1.dp),      32'(m_dp[1]));
    check("u1_step",    32'(bus1.step),    32'(m_step[1]));
    check("u1_seq_err", 32'(bus1.seq_err), 32'(m_seq[1]));
    check("u1_bad_pat", 32'(bus1.bad_pat), 32'(m_bad[1]));
    check("u1_stall",   32'(bus1.stall),   32'(m_stall[1]));
    check("u1_err_cnt", 32'(bus1.err_cnt), 32'(m_err[1]));
    cnt_step0  += int'(bus0.step);
    cnt_seq0   += int'(bus0.seq_err);
    cnt_bad0   += int'(bus0.bad_pat);
    cnt_stall0 += int'(bus0.stall);
  endtask

  // Hold a logical pattern for n edges; u1 sees it inverted.
  task automatic drive(input logic [7:0] pat, input int n);
    repeat (n) begin
      @(negedge clk);
      bus0.seg = pat;
      bus1.seg = ~pat;
      @(posedge clk);
      model_step(0, pat);
      model_step(1, pat);
      #1 compare_all();
    end
  endtask

  // Assert reset between edges: outputs must clear without waiting for a clock.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_u0_digit", 32'(bus0.digit),   32'd0);
    check("rst_u0_valid", 32'(bus0.valid),   32'd0);
    check("rst_u0_dp",    32'(bus0.dp),      32'd0);
    check("rst_u0_pulse", 32'({bus0.step, bus0.seq_err, bus0.bad_pat, bus0.stall}), 32'd0);
    check("rst_u0_err",   32'(bus0.err_cnt), 32'd0);
    check("rst_u1_digit", 32'(bus1.digit),   32'd0);
    check("rst_u1_valid", 32'(bus1.valid),   32'd0);
    check("rst_u1_err",   32'(bus1.err_cnt), 32'd0);
    model_reset();
    @(posedge clk);
    #2 rst = 1'b1;
  endtask

  logic [7:0] count_seq [11] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D,
                                 8'h7D, 8'h07, 8'h7F, 8'h6F, 8'h3F};
  logic [7:0] illegal   [5]  = '{8'h49, 8'h4A, 8'h01, 8'h7E, 8'h12};

  initial begin
    int base_step, base_seq, base_stall, lastd, kind, hold;
    logic [7:0] p;
    bus0.seg = 8'h00;
    bus1.seg = 8'hFF;
    do_reset();

    // Full count 0..9..0: one load plus ten steps, no errors.
    cnt_step0 = 0;
    cnt_seq0  = 0;
    foreach (count_seq[k]) drive(count_seq[k], 3);
    check("cnt_steps",  32'(cnt_step0),    32'd10);
    check("cnt_seqerr", 32'(cnt_seq0),     32'd0);
    check("cnt_digit",  32'(bus0.digit),   32'd0);
    check("cnt_valid",  32'(bus0.valid),   32'd1);
    check("cnt_err",    32'(bus0.err_cnt), 32'd0);

    // Skip from 2 to 4, then resume counting.
    drive(8'h06, 3);
    drive(8'h5B, 3);
    base_seq = cnt_seq0;
    drive(8'h66, 3);
    check("skip_seq",   32'(cnt_seq0 - base_seq), 32'd1);
    check("skip_digit", 32'(bus0.digit),   32'd4);
    check("skip_err",   32'(bus0.err_cnt), 32'd1);
    base_step = cnt_step0;
    drive(8'h6D, 3);
    check("skip_step",  32'(cnt_step0 - base_step), 32'd1);

    // Back to 2 (second seq_err), step to 3, single-edge glitch inside the hold.
    drive(8'h5B, 3);
    drive(8'h4F, 3);
    base_step = cnt_step0;
    base_seq  = cnt_seq0;
    drive(8'h7F, 1);
    drive(8'h4F, 3);
    check("glitch_pulses", 32'((cnt_step0 - base_step) + (cnt_seq0 - base_seq)), 32'd0);
    check("glitch_digit",  32'(bus0.digit),   32'd3);
    drive(8'h49, 2);
    check("illegal_valid", 32'(bus0.valid),   32'd0);
    check("illegal_digit", 32'(bus0.digit),   32'd3);
    check("illegal_err",   32'(bus0.err_cnt), 32'd3);

    // Stall: 06 held for TIMEOUT+2 edges after a reload to 0.
    drive(8'h3F, 3);
    base_stall = cnt_stall0;
    drive(8'h06, T0 + 2);
    check("stall_count", 32'(cnt_stall0 - base_stall), 32'd1);
    check("stall_valid", 32'(bus0.valid), 32'd0);
    base_step = cnt_step0;
    drive(8'h5B, 3);
    check("reload_valid", 32'(bus0.valid), 32'd1);
    check("reload_digit", 32'(bus0.digit), 32'd2);
    check("reload_step",  32'(cnt_step0 - base_step), 32'd0);

    // Randomized traffic, mostly counting, with skips, blanks, illegals, dp
    // toggles, glitches and occasional long holds.
    lastd = 2;
    for (int it = 0; it < 400; it++) begin
      kind = int'($urandom_range(0, 9));
      p = 8'h00;
      if (kind <= 5) begin
        lastd = (lastd + 1) % 10;
        p = {1'($urandom_range(0, 1)), pats[lastd]};
      end else if (kind == 6) begin
        lastd = int'($urandom_range(0, 9));
        p = {1'($urandom_range(0, 1)), pats[lastd]};
      end else if (kind == 7) begin
        p = {1'($urandom_range(0, 1)), 7'h00};
      end else if (kind == 8) begin
        p = illegal[$urandom_range(0, 4)];
      end else begin
        p = {1'($urandom_range(0, 1)), pats[lastd]};
      end
      hold = ($urandom_range(0, 7) == 0) ? 20 : int'($urandom_range(1, 4));
      drive(p, hold);
      if ($urandom_range(0, 5) == 0) drive(illegal[$urandom_range(0, 4)], 1);
    end

    // Force 300 illegal acceptances: the counter must pin at 255.
    for (int k = 0; k < 300; k++) drive((k % 2 == 0) ? 8'h49 : 8'h4A, 2);
    check("sat_u0", 32'(bus0.err_cnt), 32'hFF);
    check("sat_u1", 32'(bus1.err_cnt), 32'hFF);

    // Reset in the middle of a count, then restart from scratch.
    drive(8'h3F, 3);
    drive(8'h06, 1);
    do_reset();
    drive(8'h06, 3);
    drive(8'h5B, 3);
    check("post_rst_digit", 32'(bus0.digit), 32'd2);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Safety net in case the stimulus ever stops advancing.
  initial begin
    #5ms;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
